// File: rtl/alu_pkg.sv
// Shared ALU encodings, decode helper and EX-stage register layout for the ID/EX stage.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package alu_pkg;

  // The ALU datapath is fixed at 32 bits, and register addresses are 5 bits.
  localparam int ALU_W  = 32;
  localparam int REG_AW = 5;

  // ALU mode codes. m[2] drives the ALU carry-in/invert, so SUB and SLT both have it set.
  typedef enum logic [2:0] {
    ALU_OR   = 3'b000,
    ALU_AND  = 3'b001,
    ALU_XOR  = 3'b010,
    ALU_ADD  = 3'b011,
    ALU_NOR  = 3'b100,
    ALU_NAND = 3'b101,
    ALU_SLT  = 3'b110,
    ALU_SUB  = 3'b111
  } alu_m_e;

  // Main-decoder alu_op classes.
  typedef enum logic [1:0] {
    ALUOP_MEM   = 2'b00,  // load/store address: ADD
    ALUOP_BR    = 2'b01,  // branch compare: SUB
    ALUOP_RTYPE = 2'b10,  // use funct field
    ALUOP_ORI   = 2'b11   // OR-immediate
  } alu_op_e;

  // R-type funct field values.
  localparam logic [5:0] FUNCT_ADD  = 6'h20;
  localparam logic [5:0] FUNCT_SUB  = 6'h22;
  localparam logic [5:0] FUNCT_AND  = 6'h24;
  localparam logic [5:0] FUNCT_OR   = 6'h25;
  localparam logic [5:0] FUNCT_XOR  = 6'h26;
  localparam logic [5:0] FUNCT_NOR  = 6'h27;
  localparam logic [5:0] FUNCT_SLT  = 6'h2A;
  localparam logic [5:0] FUNCT_NAND = 6'h2C;

  // Everything the EX stage holds for one instruction.
  typedef struct packed {
    logic               valid;
    logic               reg_write;
    logic               mem_read;
    logic               mem_write;
    logic               alu_src;
    alu_m_e             m;
    logic [REG_AW-1:0]  rd;
    logic [REG_AW-1:0]  rs1;
    logic [REG_AW-1:0]  rs2;
    logic [ALU_W-1:0]   rs1_data;
    logic [ALU_W-1:0]   rs2_data;
    logic [ALU_W-1:0]   imm;
  } ex_regs_t;

  // A bubble has every control low, m = OR, and zeroed data so nothing stale lingers.
  localparam ex_regs_t EX_BUBBLE = '0;

  // Map alu_op/funct to the ALU mode; unknown funct values fall back to ADD.
  function automatic alu_m_e alu_decode(input logic [1:0] alu_op, input logic [5:0] funct);
    alu_m_e m;
    m = ALU_ADD;
    case (alu_op)
      ALUOP_MEM: m = ALU_ADD;
      ALUOP_BR:  m = ALU_SUB;
      ALUOP_ORI: m = ALU_OR;
      default: begin
        case (funct)
          FUNCT_ADD:  m = ALU_ADD;
          FUNCT_SUB:  m = ALU_SUB;
          FUNCT_AND:  m = ALU_AND;
          FUNCT_OR:   m = ALU_OR;
          FUNCT_XOR:  m = ALU_XOR;
          FUNCT_NOR:  m = ALU_NOR;
          FUNCT_SLT:  m = ALU_SLT;
          FUNCT_NAND: m = ALU_NAND;
          default:    m = ALU_ADD;
        endcase
      end
    endcase
    return m;
  endfunction

endpackage

// File: rtl/fwd_unit.sv
// Operand forwarding mux: picks EX/MEM, then MEM/WB, then register-file data for one source register.
// Latency: combinational.
// Backpressure: none; pure function of its inputs.
module fwd_unit
  import alu_pkg::*;
#(
  parameter int W  = ALU_W,
  parameter int AW = REG_AW
) (
  input  logic [AW-1:0] rs,
  input  logic [W-1:0]  rf_data,
  input  logic          exmem_we,
  input  logic [AW-1:0] exmem_rd,
  input  logic [W-1:0]  exmem_data,
  input  logic          memwb_we,
  input  logic [AW-1:0] memwb_rd,
  input  logic [W-1:0]  memwb_data,
  output logic [W-1:0]  fwd_data
);

  // Later assignment wins, so the younger EX/MEM result overrides MEM/WB; x0 is never forwarded.
  always_comb begin
    fwd_data = rf_data;
    if (memwb_we && (memwb_rd != '0) && (memwb_rd == rs)) begin
      fwd_data = memwb_data;
    end
    if (exmem_we && (exmem_rd != '0) && (exmem_rd == rs)) begin
      fwd_data = exmem_data;
    end
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with ALU-mode decode, load-use bubble and EX/MEM, MEM/WB operand forwarding.
// Latency: 1 clk from ID inputs to EX outputs; load_use_stall is combinational.
// Backpressure: stall holds all stage registers; flush/load-use load a bubble. Forwarding needs ID_EX_FWD_EN.
module id_ex_stage
  import alu_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int RADDR_W = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall,
  input  logic               flush,
  input  logic               id_valid,
  input  logic [XLEN-1:0]    id_rs1_data,
  input  logic [XLEN-1:0]    id_rs2_data,
  input  logic [XLEN-1:0]    id_imm,
  input  logic [RADDR_W-1:0] id_rs1,
  input  logic [RADDR_W-1:0] id_rs2,
  input  logic [RADDR_W-1:0] id_rd,
  input  logic [1:0]         id_alu_op,
  input  logic [5:0]         id_funct,
  input  logic               id_alu_src,
  input  logic               id_reg_write,
  input  logic               id_mem_read,
  input  logic               id_mem_write,
  input  logic               exmem_reg_write,
  input  logic [RADDR_W-1:0] exmem_rd,
  input  logic [XLEN-1:0]    exmem_result,
  input  logic               memwb_reg_write,
  input  logic [RADDR_W-1:0] memwb_rd,
  input  logic [XLEN-1:0]    memwb_result,
  output logic [XLEN-1:0]    alu_a,
  output logic [XLEN-1:0]    alu_b,
  output logic [2:0]         alu_m,
  output logic               ex_valid,
  output logic               ex_reg_write,
  output logic               ex_mem_read,
  output logic               ex_mem_write,
  output logic [RADDR_W-1:0] ex_rd,
  output logic [XLEN-1:0]    ex_store_data,
  output logic               load_use_stall
);

  // With forwarding compiled out the bypass enables are tied low, leaving only register-file data.
`ifdef ID_EX_FWD_EN
  localparam logic FWD_ON = 1'b1;
`else
  localparam logic FWD_ON = 1'b0;
`endif

  ex_regs_t ex_q;
  ex_regs_t ex_d;
  ex_regs_t id_fields;

  logic [XLEN-1:0] rs1_fwd;
  logic [XLEN-1:0] rs2_fwd;

  // A load in EX whose destination is read by ID must wait one cycle; rs2 only matters when it is
  // actually consumed (as ALU operand B or as store data).
  assign load_use_stall = ex_q.valid && ex_q.mem_read && (ex_q.rd != '0) && id_valid &&
                          ((id_rs1 == ex_q.rd) ||
                           ((id_rs2 == ex_q.rd) && (!id_alu_src || id_mem_write)));

  // Decode in ID and pack the fields that EX will hold; controls are killed for non-instructions.
  always_comb begin
    id_fields           = EX_BUBBLE;
    id_fields.valid     = id_valid;
    id_fields.reg_write = id_reg_write & id_valid;
    id_fields.mem_read  = id_mem_read & id_valid;
    id_fields.mem_write = id_mem_write & id_valid;
    id_fields.alu_src   = id_alu_src;
    id_fields.m         = alu_decode(id_alu_op, id_funct);
    id_fields.rd        = id_rd;
    id_fields.rs1       = id_rs1;
    id_fields.rs2       = id_rs2;
    id_fields.rs1_data  = id_rs1_data;
    id_fields.rs2_data  = id_rs2_data;
    id_fields.imm       = id_imm;
  end

  // Next-state priority: flush beats stall, stall beats the load-use bubble, then normal capture.
  always_comb begin
    ex_d = ex_q;
    if (flush) begin
      ex_d = EX_BUBBLE;
    end else if (stall) begin
      ex_d = ex_q;
    end else if (load_use_stall) begin
      ex_d = EX_BUBBLE;
    end else begin
      ex_d = id_fields;
    end
  end

  // Stage register; reset clears it asynchronously so no held or stalled state survives.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_q <= EX_BUBBLE;
    end else begin
      ex_q <= ex_d;
    end
  end

  fwd_unit #(.W(XLEN), .AW(RADDR_W)) u_fwd_rs1 (
    .rs         (ex_q.rs1),
    .rf_data    (ex_q.rs1_data),
    .exmem_we   (FWD_ON & exmem_reg_write),
    .exmem_rd   (exmem_rd),
    .exmem_data (exmem_result),
    .memwb_we   (FWD_ON & memwb_reg_write),
    .memwb_rd   (memwb_rd),
    .memwb_data (memwb_result),
    .fwd_data   (rs1_fwd)
  );

  fwd_unit #(.W(XLEN), .AW(RADDR_W)) u_fwd_rs2 (
    .rs         (ex_q.rs2),
    .rf_data    (ex_q.rs2_data),
    .exmem_we   (FWD_ON & exmem_reg_write),
    .exmem_rd   (exmem_rd),
    .exmem_data (exmem_result),
    .memwb_we   (FWD_ON & memwb_reg_write),
    .memwb_rd   (memwb_rd),
    .memwb_data (memwb_result),
    .fwd_data   (rs2_fwd)
  );

  assign alu_a         = rs1_fwd;
  assign alu_b         = ex_q.alu_src ? ex_q.imm : rs2_fwd;
  assign ex_store_data = rs2_fwd;
  assign alu_m         = ex_q.m;
  assign ex_valid      = ex_q.valid;
  assign ex_reg_write  = ex_q.reg_write;
  assign ex_mem_read   = ex_q.mem_read;
  assign ex_mem_write  = ex_q.mem_write;
  assign ex_rd         = ex_q.rd;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: decode vector table plus forwarding, load-use, stall/flush and reset sequences.
// Latency: expects EX outputs 1 clk after ID inputs.
// Backpressure: exercises stall, flush and the load-use bubble.
module tb_id_ex_stage;

`ifdef ID_EX_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        stall;
  logic        flush;
  logic        id_valid;
  logic [31:0] id_rs1_data;
  logic [31:0] id_rs2_data;
  logic [31:0] id_imm;
  logic [4:0]  id_rs1;
  logic [4:0]  id_rs2;
  logic [4:0]  id_rd;
  logic [1:0]  id_alu_op;
  logic [5:0]  id_funct;
  logic        id_alu_src;
  logic        id_reg_write;
  logic        id_mem_read;
  logic        id_mem_write;
  logic        exmem_reg_write;
  logic [4:0]  exmem_rd;
  logic [31:0] exmem_result;
  logic        memwb_reg_write;
  logic [4:0]  memwb_rd;
  logic [31:0] memwb_result;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [2:0]  alu_m;
  logic        ex_valid;
  logic        ex_reg_write;
  logic        ex_mem_read;
  logic        ex_mem_write;
  logic [4:0]  ex_rd;
  logic [31:0] ex_store_data;
  logic        load_use_stall;

  int checks;
  int failures;

  id_ex_stage dut (
    .clk             (clk),
    .rst             (rst),
    .stall           (stall),
    .flush           (flush),
    .id_valid        (id_valid),
    .id_rs1_data     (id_rs1_data),
    .id_rs2_data     (id_rs2_data),
    .id_imm          (id_imm),
    .id_rs1          (id_rs1),
    .id_rs2          (id_rs2),
    .id_rd           (id_rd),
    .id_alu_op       (id_alu_op),
    .id_funct        (id_funct),
    .id_alu_src      (id_alu_src),
    .id_reg_write    (id_reg_write),
    .id_mem_read     (id_mem_read),
    .id_mem_write    (id_mem_write),
    .exmem_reg_write (exmem_reg_write),
    .exmem_rd        (exmem_rd),
    .exmem_result    (exmem_result),
    .memwb_reg_write (memwb_reg_write),
    .memwb_rd        (memwb_rd),
    .memwb_result    (memwb_result),
    .alu_a           (alu_a),
    .alu_b           (alu_b),
    .alu_m           (alu_m),
    .ex_valid        (ex_valid),
    .ex_reg_write    (ex_reg_write),
    .ex_mem_read     (ex_mem_read),
    .ex_mem_write    (ex_mem_write),
    .ex_rd           (ex_rd),
    .ex_store_data   (ex_store_data),
    .load_use_stall  (load_use_stall)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic set_id(input logic [1:0] op, input logic [5:0] fn, input logic src,
                        input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                        input logic [31:0] d1, input logic [31:0] d2, input logic [31:0] imm,
                        input logic rw, input logic mr, input logic mw);
    id_valid     = 1'b1;
    id_alu_op    = op;
    id_funct     = fn;
    id_alu_src   = src;
    id_rs1       = rs1;
    id_rs2       = rs2;
    id_rd        = rd;
    id_rs1_data  = d1;
    id_rs2_data  = d2;
    id_imm       = imm;
    id_reg_write = rw;
    id_mem_read  = mr;
    id_mem_write = mw;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [1:0]  op;
    logic [5:0]  fn;
    logic        src;
    logic [31:0] d1;
    logic [31:0] d2;
    logic [31:0] imm;
    logic [2:0]  exp_m;
    logic [31:0] exp_a;
    logic [31:0] exp_b;
  } vec_t;

  vec_t vecs[12];

  initial begin
    checks   = 0;
    failures = 0;

    // Decode table: {alu_op, funct, alu_src, rs1_data, rs2_data, imm, m, alu_a, alu_b}
    vecs[0]  = '{2'b10, 6'h22, 1'b0, 32'd9,   32'd4,  32'd0,         3'b111, 32'd9,   32'd4};
    vecs[1]  = '{2'b00, 6'h00, 1'b1, 32'd100, 32'd55, 32'hFFFFFFF0,  3'b011, 32'd100, 32'hFFFFFFF0};
    vecs[2]  = '{2'b10, 6'h3F, 1'b0, 32'd1,   32'd2,  32'd0,         3'b011, 32'd1,   32'd2};
    vecs[3]  = '{2'b10, 6'h24, 1'b0, 32'hF0,  32'h3C, 32'd0,         3'b001, 32'hF0,  32'h3C};
    vecs[4]  = '{2'b10, 6'h25, 1'b0, 32'h11,  32'h22, 32'd0,         3'b000, 32'h11,  32'h22};
    vecs[5]  = '{2'b10, 6'h26, 1'b0, 32'h33,  32'h44, 32'd0,         3'b010, 32'h33,  32'h44};
    vecs[6]  = '{2'b10, 6'h27, 1'b0, 32'h55,  32'h66, 32'd0,         3'b100, 32'h55,  32'h66};
    vecs[7]  = '{2'b10, 6'h2A, 1'b0, 32'h77,  32'h88, 32'd0,         3'b110, 32'h77,  32'h88};
    vecs[8]  = '{2'b10, 6'h2C, 1'b0, 32'h99,  32'hAB, 32'd0,         3'b101, 32'h99,  32'hAB};
    vecs[9]  = '{2'b10, 6'h20, 1'b0, 32'h5,   32'h6,  32'd0,         3'b011, 32'h5,   32'h6};
    vecs[10] = '{2'b01, 6'h25, 1'b0, 32'h12,  32'h34, 32'd0,         3'b111, 32'h12,  32'h34};
    vecs[11] = '{2'b11, 6'h22, 1'b1, 32'h0F,  32'h99, 32'h000000F0,  3'b000, 32'h0F,  32'h000000F0};

    rst = 1'b1; stall = 1'b0; flush = 1'b0;
    id_valid = 1'b0; id_rs1_data = '0; id_rs2_data = '0; id_imm = '0;
    id_rs1 = '0; id_rs2 = '0; id_rd = '0; id_alu_op = '0; id_funct = '0;
    id_alu_src = 1'b0; id_reg_write = 1'b0; id_mem_read = 1'b0; id_mem_write = 1'b0;
    exmem_reg_write = 1'b0; exmem_rd = '0; exmem_result = '0;
    memwb_reg_write = 1'b0; memwb_rd = '0; memwb_result = '0;

    // Reset state
    #12;
    check("rst_ex_valid", {31'd0, ex_valid}, 32'd0);
    check("rst_alu_m", {29'd0, alu_m}, 32'd0);
    check("rst_alu_a", alu_a, 32'd0);
    check("rst_alu_b", alu_b, 32'd0);
    check("rst_ex_rd", {27'd0, ex_rd}, 32'd0);
    check("rst_ctrl", {28'd0, ex_reg_write, ex_mem_read, ex_mem_write, 1'b0}, 32'd0);
    check("rst_lus", {31'd0, load_use_stall}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Decode vectors, no hazards
    for (int i = 0; i < 12; i++) begin
      set_id(vecs[i].op, vecs[i].fn, vecs[i].src, 5'd1, 5'd2, 5'd7,
             vecs[i].d1, vecs[i].d2, vecs[i].imm, 1'b1, 1'b0, 1'b0);
      tick();
      check($sformatf("vec%0d_m", i), {29'd0, alu_m}, {29'd0, vecs[i].exp_m});
      check($sformatf("vec%0d_a", i), alu_a, vecs[i].exp_a);
      check($sformatf("vec%0d_b", i), alu_b, vecs[i].exp_b);
      check($sformatf("vec%0d_vld", i), {30'd0, ex_valid, ex_reg_write}, 32'd3);
    end

    // Forwarding priority
    set_id(2'b10, 6'h20, 1'b0, 5'd5, 5'd6, 5'd8, 32'h11, 32'h22, 32'd0, 1'b1, 1'b0, 1'b0);
    tick();
    exmem_reg_write = 1'b1; exmem_rd = 5'd5; exmem_result = 32'hAA;
    memwb_reg_write = 1'b1; memwb_rd = 5'd5; memwb_result = 32'hBB;
    #1;
    check("fwd_exmem_prio", alu_a, FWD ? 32'hAA : 32'h11);
    exmem_rd = 5'd0;
    #1;
    check("fwd_memwb", alu_a, FWD ? 32'hBB : 32'h11);
    memwb_rd = 5'd0;
    #1;
    check("fwd_rd0_raw", alu_a, 32'h11);
    memwb_rd = 5'd6; exmem_rd = 5'd6; exmem_reg_write = 1'b0;
    #1;
    check("fwd_rs2_alu_b", alu_b, FWD ? 32'hBB : 32'h22);
    check("fwd_rs2_store", ex_store_data, FWD ? 32'hBB : 32'h22);
    exmem_reg_write = 1'b0; memwb_reg_write = 1'b0; exmem_rd = '0; memwb_rd = '0;

    // Load-use hazard
    set_id(2'b00, 6'h00, 1'b1, 5'd1, 5'd0, 5'd3, 32'd100, 32'd0, 32'd4, 1'b1, 1'b1, 1'b0);
    tick();
    check("lw_in_ex", {30'd0, ex_valid, ex_mem_read}, 32'd3);
    set_id(2'b00, 6'h00, 1'b1, 5'd2, 5'd3, 5'd4, 32'd1, 32'd2, 32'd8, 1'b1, 1'b0, 1'b0);
    #1;
    check("lus_imm_no_stall", {31'd0, load_use_stall}, 32'd0);
    set_id(2'b10, 6'h20, 1'b0, 5'd2, 5'd3, 5'd4, 32'd1, 32'd2, 32'd0, 1'b1, 1'b0, 1'b0);
    #1;
    check("lus_asserted", {31'd0, load_use_stall}, 32'd1);
    tick();
    check("lus_bubble_vld", {30'd0, ex_valid, ex_reg_write}, 32'd0);
    check("lus_bubble_m", {29'd0, alu_m}, 32'd0);
    check("lus_released", {31'd0, load_use_stall}, 32'd0);
    tick();
    check("lus_reload_vld", {31'd0, ex_valid}, 32'd1);
    check("lus_reload_m", {29'd0, alu_m}, 32'd3);
    check("lus_reload_rd", {27'd0, ex_rd}, 32'd4);
    check("lus_reload_b", alu_b, 32'd2);

    // Stall holds, flush beats stall
    set_id(2'b10, 6'h22, 1'b0, 5'd1, 5'd2, 5'd10, 32'd9, 32'd4, 32'd0, 1'b1, 1'b0, 1'b0);
    tick();
    stall = 1'b1;
    set_id(2'b10, 6'h20, 1'b0, 5'd1, 5'd2, 5'd11, 32'd7, 32'd8, 32'd0, 1'b1, 1'b0, 1'b0);
    tick();
    check("stall_m", {29'd0, alu_m}, 32'd7);
    check("stall_a", alu_a, 32'd9);
    check("stall_b", alu_b, 32'd4);
    check("stall_rd", {27'd0, ex_rd}, 32'd10);
    check("stall_vld", {31'd0, ex_valid}, 32'd1);
    flush = 1'b1;
    tick();
    check("flush_vld", {30'd0, ex_valid, ex_reg_write}, 32'd0);
    check("flush_m", {29'd0, alu_m}, 32'd0);
    check("flush_a", alu_a, 32'd0);
    check("flush_rd", {27'd0, ex_rd}, 32'd0);
    stall = 1'b0; flush = 1'b0;

    // Asynchronous reset mid-cycle
    set_id(2'b10, 6'h22, 1'b0, 5'd1, 5'd2, 5'd10, 32'd9, 32'd4, 32'd0, 1'b1, 1'b0, 1'b0);
    tick();
    check("pre_rst_vld", {31'd0, ex_valid}, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("arst_vld", {31'd0, ex_valid}, 32'd0);
    check("arst_a", alu_a, 32'd0);
    check("arst_m", {29'd0, alu_m}, 32'd0);
    check("arst_rd", {27'd0, ex_rd}, 32'd0);
    tick();
    check("arst_hold_vld", {31'd0, ex_valid}, 32'd0);
    check("arst_hold_b", alu_b, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    tick();
    check("post_rst_vld", {31'd0, ex_valid}, 32'd1);
    check("post_rst_m", {29'd0, alu_m}, 32'd7);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
